nibble_control: RTL and testbench

- Fetch/execute controller that drives the 4-bit operational unit (accumulator, ALU, operand buffer, output buffer).
- Reads 8-bit program bytes {opcode[7:4], operand[3:0]} from an asynchronous-read program ROM.
- Generates the unit's enables and ALU select, keeps C/Z flags, and sequences the PC, including conditional jumps.

---
 rtl/nibble_pkg.sv | 87 ++++++++
 rtl/nibble_decode.sv | 47 ++++
 rtl/nibble_control.sv | 147 ++++++++++++++
 tb/tb_nibble_control.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_pkg.sv
// nibble_pkg: shared opcodes, FSM states, ALU select codes and control-word layout
// for the nibble fetch/execute controller.
// Optional feature macro: NIBBLE_CALL_RET_EN (enables the CALL/RET opcodes).
package nibble_pkg;

    // Opcode values carried in IR[7:4]
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LIT  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_CMP  = 4'h4;
    localparam logic [3:0] OP_NOR  = 4'h5;
    localparam logic [3:0] OP_OUT  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JC   = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JNZ  = 4'hB;
    localparam logic [3:0] OP_CALL = 4'hC;
    localparam logic [3:0] OP_RET  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Controller states
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // ALU select codes
    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_PASS_B = 3'b010;
    localparam logic [2:0] ALU_ADD    = 3'b011;
    localparam logic [2:0] ALU_NOR    = 3'b100;

    // Control-word bit positions
    localparam int CW_IS_HALT = 0;
    localparam int CW_IS_JUMP = 1;
    localparam int CW_FLAG_WE = 2;
    localparam int CW_S_LSB   = 3;
    localparam int CW_S_MSB   = 5;
    localparam int CW_ENC     = 6;
    localparam int CW_ENB     = 7;
    localparam int CW_ENA     = 8;
    localparam int CW_W       = 9;

    typedef logic [CW_W-1:0] ctrl_word_t;

    // Pack individual control fields into a control word at their fixed positions
    function automatic ctrl_word_t make_cw(
        input logic       ena,
        input logic       enb,
        input logic       enc,
        input logic [2:0] s,
        input logic       flag_we,
        input logic       is_jump,
        input logic       is_halt
    );
        ctrl_word_t cw;
        cw                      = '0;
        cw[CW_ENA]              = ena;
        cw[CW_ENB]              = enb;
        cw[CW_ENC]              = enc;
        cw[CW_S_MSB:CW_S_LSB]   = s;
        cw[CW_FLAG_WE]          = flag_we;
        cw[CW_IS_JUMP]          = is_jump;
        cw[CW_IS_HALT]          = is_halt;
        return cw;
    endfunction

    // Jump condition from opcode[1:0]: 00 always, 01 carry, 10 zero, 11 not zero
    function automatic logic jump_taken(
        input logic [1:0] cond,
        input logic       c_flag,
        input logic       z_flag
    );
        logic taken;
        case (cond)
            2'b00:   taken = 1'b1;
            2'b01:   taken = c_flag;
            2'b10:   taken = z_flag;
            default: taken = ~z_flag;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/nibble_decode.sv
// nibble_decode: purely combinational opcode decoder producing the EXEC-phase
// control fields for the operational unit.
// Optional feature macro: NIBBLE_CALL_RET_EN (CALL decodes as an unconditional jump).
module nibble_decode (
    input  logic [3:0] opcode,
    output logic       ena,
    output logic       enb,
    output logic       enc,
    output logic [2:0] s,
    output logic       flag_we,
    output logic       is_jump,
    output logic       is_halt
);
    import nibble_pkg::*;

    ctrl_word_t cw;

    // Map each opcode to its control word; undefined opcodes fall through as NOP
    always_comb begin
        cw = make_cw(1'b0, 1'b0, 1'b0, ALU_PASS_A, 1'b0, 1'b0, 1'b0);
        case (opcode)
            OP_LIT:  cw = make_cw(1'b1, 1'b1, 1'b0, ALU_PASS_B, 1'b0, 1'b0, 1'b0);
            OP_ADD:  cw = make_cw(1'b1, 1'b1, 1'b0, ALU_ADD,    1'b1, 1'b0, 1'b0);
            OP_SUB:  cw = make_cw(1'b1, 1'b1, 1'b0, ALU_SUB,    1'b1, 1'b0, 1'b0);
            OP_CMP:  cw = make_cw(1'b0, 1'b1, 1'b0, ALU_SUB,    1'b1, 1'b0, 1'b0);
            OP_NOR:  cw = make_cw(1'b1, 1'b1, 1'b0, ALU_NOR,    1'b1, 1'b0, 1'b0);
            OP_OUT:  cw = make_cw(1'b0, 1'b0, 1'b1, ALU_PASS_A, 1'b0, 1'b0, 1'b0);
            OP_JMP, OP_JC, OP_JZ, OP_JNZ:
                     cw = make_cw(1'b0, 1'b0, 1'b0, ALU_PASS_A, 1'b0, 1'b1, 1'b0);
`ifdef NIBBLE_CALL_RET_EN
            // CALL's low opcode bits are 00, so the jump condition reads "always"
            OP_CALL: cw = make_cw(1'b0, 1'b0, 1'b0, ALU_PASS_A, 1'b0, 1'b1, 1'b0);
`endif
            OP_HALT: cw = make_cw(1'b0, 1'b0, 1'b0, ALU_PASS_A, 1'b0, 1'b0, 1'b1);
            default: ;
        endcase
    end

    assign ena     = cw[CW_ENA];
    assign enb     = cw[CW_ENB];
    assign enc     = cw[CW_ENC];
    assign s       = cw[CW_S_MSB:CW_S_LSB];
    assign flag_we = cw[CW_FLAG_WE];
    assign is_jump = cw[CW_IS_JUMP];
    assign is_halt = cw[CW_IS_HALT];

endmodule

// File: rtl/nibble_control.sv
// nibble_control: two-phase fetch/execute controller for the 4-bit operational unit.
// Holds the FSM, program counter, instruction register and C/Z flags; control
// outputs are Moore-decoded from IR while in EXEC.
// Optional feature macro: NIBBLE_CALL_RET_EN (CALL/RET with a one-entry return register).
module nibble_control #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [7:0]        prog_data,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        oprnd,
    output logic              ena,
    output logic              enb,
    output logic              enc,
    output logic [2:0]        s,
    input  logic              c_in,
    input  logic              zero_in,
    output logic              c_flag,
    output logic              z_flag,
    output logic              halted,
    output logic              phase
);
    import nibble_pkg::*;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic              c_flag_q, c_flag_d;
    logic              z_flag_q, z_flag_d;
`ifdef NIBBLE_CALL_RET_EN
    logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;
`endif

    logic       dec_ena, dec_enb, dec_enc;
    logic [2:0] dec_s;
    logic       dec_flag_we, dec_is_jump, dec_is_halt;

    nibble_decode u_decode (
        .opcode  (ir_q[7:4]),
        .ena     (dec_ena),
        .enb     (dec_enb),
        .enc     (dec_enc),
        .s       (dec_s),
        .flag_we (dec_flag_we),
        .is_jump (dec_is_jump),
        .is_halt (dec_is_halt)
    );

    // State register: synchronous reset has priority over every update
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            ir_q     <= 8'h00;
            c_flag_q <= 1'b0;
            z_flag_q <= 1'b0;
`ifdef NIBBLE_CALL_RET_EN
            ret_pc_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            c_flag_q <= c_flag_d;
            z_flag_q <= z_flag_d;
`ifdef NIBBLE_CALL_RET_EN
            ret_pc_q <= ret_pc_d;
`endif
        end
    end

    // Next-state logic: fetch, execute (flags, jumps, halt) and the terminal halt
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        c_flag_d = c_flag_q;
        z_flag_d = z_flag_q;
`ifdef NIBBLE_CALL_RET_EN
        ret_pc_d = ret_pc_q;
`endif
        case (state_q)
            ST_FETCH: begin
                if (run) begin
                    ir_d    = prog_data;
                    pc_d    = pc_q + PC_ONE;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = dec_is_halt ? ST_HALT : ST_FETCH;
                if (dec_flag_we) begin
                    c_flag_d = c_in;
                    z_flag_d = zero_in;
                end
                // Two-byte instructions: prog_data is the target byte at pc_q
                if (dec_is_jump) begin
                    if (jump_taken(ir_q[5:4], c_flag_q, z_flag_q)) begin
                        pc_d = prog_data[ADDR_W-1:0];
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
`ifdef NIBBLE_CALL_RET_EN
                if (ir_q[7:4] == OP_CALL) begin
                    ret_pc_d = pc_q + PC_ONE;
                end
                if (ir_q[7:4] == OP_RET) begin
                    pc_d = ret_pc_q;
                end
`endif
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Output logic: unit enables only drive during EXEC, everything else is status
    always_comb begin
        ena    = 1'b0;
        enb    = 1'b0;
        enc    = 1'b0;
        s      = ALU_PASS_A;
        phase  = (state_q == ST_EXEC);
        halted = (state_q == ST_HALT);
        if (state_q == ST_EXEC) begin
            ena = dec_ena;
            enb = dec_enb;
            enc = dec_enc;
            s   = dec_s;
        end
    end

    assign pc     = pc_q;
    assign oprnd  = ir_q[3:0];
    assign c_flag = c_flag_q;
    assign z_flag = z_flag_q;

endmodule

// File: tb/tb_nibble_control.sv
// tb_nibble_control: table-driven single-instruction vectors with a scoreboard
// queue, plus hand-written multi-cycle sequences. A second instance with
// ADDR_W=4 shares the ROM to exercise narrow PC wrap-around.
// Optional feature macro: NIBBLE_CALL_RET_EN (changes CALL/RET expectations).
module tb_nibble_control;

    logic       clk;
    logic       reset;
    logic       run;
    logic       c_in;
    logic       zero_in;
    logic [7:0] prog_data;
    logic [7:0] pc;
    logic [3:0] oprnd;
    logic       ena, enb, enc;
    logic [2:0] s;
    logic       c_flag, z_flag, halted, phase;

    logic [7:0] prog_data4;
    logic [3:0] pc4;
    logic [3:0] oprnd4;
    logic       ena4, enb4, enc4;
    logic [2:0] s4;
    logic       c_flag4, z_flag4, halted4, phase4;

    logic [7:0] rom [256];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] instr;
        logic       c_in;
        logic       zero_in;
        logic       ena;
        logic       enb;
        logic       enc;
        logic [2:0] s;
        logic [7:0] pc_after;
        logic       c_after;
        logic       z_after;
        logic       halt_after;
    } vec_t;

    localparam int NUM_VECS = 16;
    vec_t vecs [NUM_VECS];
    vec_t exp_q [$];

    assign prog_data  = rom[pc];
    assign prog_data4 = rom[{4'h0, pc4}];

    nibble_control #(.ADDR_W(8)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .prog_data (prog_data),
        .pc        (pc),
        .oprnd     (oprnd),
        .ena       (ena),
        .enb       (enb),
        .enc       (enc),
        .s         (s),
        .c_in      (c_in),
        .zero_in   (zero_in),
        .c_flag    (c_flag),
        .z_flag    (z_flag),
        .halted    (halted),
        .phase     (phase)
    );

    nibble_control #(.ADDR_W(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .prog_data (prog_data4),
        .pc        (pc4),
        .oprnd     (oprnd4),
        .ena       (ena4),
        .enb       (enb4),
        .enc       (enc4),
        .s         (s4),
        .c_in      (c_in),
        .zero_in   (zero_in),
        .c_flag    (c_flag4),
        .z_flag    (z_flag4),
        .halted    (halted4),
        .phase     (phase4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Load one instruction at address 0 (target byte 0x40 at address 1) and start it
    task automatic applyStimulus(input vec_t v);
        clearRom();
        rom[0] = v.instr;
        rom[1] = 8'h40;
        doReset();
        c_in    = v.c_in;
        zero_in = v.zero_in;
        exp_q.push_back(v);
        run = 1'b1;
    endtask

    // Wait (bounded) for EXEC, pop the expected record and compare both phases
    task automatic scoreboardPop();
        vec_t v;
        bit   ok;
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (phase == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        v = exp_q.pop_front();
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL exec_wait_%02h: phase=%0d required 1", v.instr, phase);
            return;
        end
        run = 1'b0;
        checkOutput($sformatf("ena_%02h", v.instr), 8'(ena), 8'(v.ena));
        checkOutput($sformatf("enb_%02h", v.instr), 8'(enb), 8'(v.enb));
        checkOutput($sformatf("enc_%02h", v.instr), 8'(enc), 8'(v.enc));
        checkOutput($sformatf("s_%02h", v.instr), 8'(s), 8'(v.s));
        checkOutput($sformatf("oprnd_%02h", v.instr), 8'(oprnd), 8'(v.instr[3:0]));
        @(negedge clk);
        checkOutput($sformatf("pc_after_%02h", v.instr), pc, v.pc_after);
        checkOutput($sformatf("c_after_%02h", v.instr), 8'(c_flag), 8'(v.c_after));
        checkOutput($sformatf("z_after_%02h", v.instr), 8'(z_flag), 8'(v.z_after));
        checkOutput($sformatf("halt_after_%02h", v.instr), 8'(halted), 8'(v.halt_after));
    endtask

    // CMP sets (or clears) Z, then JZ must follow the latched flag, not live zero_in
    task automatic jzSequence(input logic zval);
        clearRom();
        rom[0] = 8'h11;
        rom[1] = 8'h41;
        rom[2] = 8'hA0;
        rom[3] = 8'h40;
        doReset();
        c_in    = 1'b0;
        zero_in = ~zval;
        run     = 1'b1;
        tick(1);
        checkOutput("jz_lit_ena", 8'(ena), 8'h01);
        tick(2);
        checkOutput("jz_cmp_ena", 8'(ena), 8'h00);
        zero_in = zval;
        tick(1);
        checkOutput("jz_zflag", 8'(z_flag), 8'(zval));
        zero_in = ~zval;
        tick(1);
        checkOutput("jz_exec_pc", pc, 8'h03);
        run = 1'b0;
        tick(1);
        checkOutput("jz_target_pc", pc, zval ? 8'h40 : 8'h04);
    endtask

    initial begin
        reset   = 1'b0;
        run     = 1'b0;
        c_in    = 1'b0;
        zero_in = 1'b0;
        clearRom();

        vecs[0]  = '{8'h15, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'h23, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{8'h37, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 8'h01, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{8'h42, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 8'h01, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 8'h01, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{8'h60, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{8'hE3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h40, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{8'h90, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{8'hA0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{8'hB0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h40, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h01, 1'b0, 1'b0, 1'b1};
`ifdef NIBBLE_CALL_RET_EN
        vecs[14] = '{8'hC5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h40, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{8'hD5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0};
`else
        vecs[14] = '{8'hC5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{8'hD5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h01, 1'b0, 1'b0, 1'b0};
`endif

        $display("[TB] reset state and run=0 hold");
        rom[0] = 8'h6C;
        doReset();
        checkOutput("rst_pc", pc, 8'h00);
        checkOutput("rst_phase", 8'(phase), 8'h00);
        checkOutput("rst_halted", 8'(halted), 8'h00);
        checkOutput("rst_en", 8'({ena, enb, enc}), 8'h00);
        checkOutput("rst_s", 8'(s), 8'h00);
        checkOutput("rst_oprnd", 8'(oprnd), 8'h00);
        checkOutput("rst_flags", 8'({c_flag, z_flag}), 8'h00);
        tick(5);
        checkOutput("hold_pc", pc, 8'h00);
        checkOutput("hold_phase", 8'(phase), 8'h00);
        checkOutput("hold_en", 8'({ena, enb, enc}), 8'h00);
        run = 1'b1;
        tick(1);
        checkOutput("first_fetch_phase", 8'(phase), 8'h01);
        checkOutput("first_fetch_oprnd", 8'(oprnd), 8'h0C);
        checkOutput("first_fetch_enc", 8'(enc), 8'h01);
        checkOutput("first_fetch_pc", pc, 8'h01);
        run = 1'b0;

        $display("[TB] single-instruction vector table");
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i]);
            scoreboardPop();
        end
        checkOutput("scoreboard_empty", 8'(exp_q.size()), 8'h00);

        $display("[TB] LIT then ADD, run dropped during EXEC");
        clearRom();
        rom[0] = 8'h15;
        rom[1] = 8'h23;
        doReset();
        run = 1'b1;
        tick(1);
        checkOutput("seq_lit_en", 8'({ena, enb, enc}), 8'h06);
        checkOutput("seq_lit_s", 8'(s), 8'h02);
        checkOutput("seq_lit_oprnd", 8'(oprnd), 8'h05);
        tick(2);
        checkOutput("seq_add_en", 8'({ena, enb, enc}), 8'h06);
        checkOutput("seq_add_s", 8'(s), 8'h03);
        checkOutput("seq_add_oprnd", 8'(oprnd), 8'h03);
        run = 1'b0;
        tick(1);
        checkOutput("seq_add_pc", pc, 8'h02);
        tick(2);
        checkOutput("seq_hold_pc", pc, 8'h02);
        checkOutput("seq_hold_phase", 8'(phase), 8'h00);

        $display("[TB] JZ on latched zero flag");
        jzSequence(1'b1);
        jzSequence(1'b0);

        $display("[TB] PC wrap and jump at max address");
        clearRom();
        rom[0]   = 8'h80;
        rom[1]   = 8'hFF;
        rom[15]  = 8'h80;
        rom[255] = 8'h80;
        doReset();
        run = 1'b1;
        tick(1);
        checkOutput("w4_exec_phase", 8'(phase4), 8'h01);
        checkOutput("w4_exec_quiet", {ena4, enb4, enc4, s4, c_flag4, z_flag4}, 8'h00);
        checkOutput("w4_exec_halted", 8'(halted4), 8'h00);
        checkOutput("w4_exec_oprnd", 8'(oprnd4), 8'h00);
        tick(1);
        checkOutput("w8_jmp_pc", pc, 8'hFF);
        checkOutput("w4_jmp_pc", 8'(pc4), 8'h0F);
        tick(1);
        checkOutput("w8_wrap_pc", pc, 8'h00);
        checkOutput("w4_wrap_pc", 8'(pc4), 8'h00);
        checkOutput("w8_wrap_phase", 8'(phase), 8'h01);
        run = 1'b0;
        tick(1);
        checkOutput("w8_maxjmp_pc", pc, 8'h80);
        checkOutput("w4_maxjmp_pc", 8'(pc4), 8'h00);

        $display("[TB] HALT and release by reset");
        clearRom();
        rom[0] = 8'hF0;
        doReset();
        run = 1'b1;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("halt_state_%0d", i), 8'({halted, phase}), 8'h02);
            checkOutput($sformatf("halt_pc_%0d", i), pc, 8'h01);
            checkOutput($sformatf("halt_en_%0d", i), 8'({ena, enb, enc, s}), 8'h00);
            tick(1);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        run   = 1'b0;
        checkOutput("halt_rst_halted", 8'(halted), 8'h00);
        checkOutput("halt_rst_pc", pc, 8'h00);

        $display("[TB] reset during EXEC aborts the instruction");
        clearRom();
        rom[0] = 8'h2F;
        doReset();
        c_in    = 1'b1;
        zero_in = 1'b1;
        run     = 1'b1;
        tick(1);
        checkOutput("abort_exec_phase", 8'(phase), 8'h01);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        run   = 1'b0;
        checkOutput("abort_pc", pc, 8'h00);
        checkOutput("abort_phase", 8'(phase), 8'h00);
        checkOutput("abort_flags", 8'({c_flag, z_flag}), 8'h00);
        checkOutput("abort_oprnd", 8'(oprnd), 8'h00);

`ifdef NIBBLE_CALL_RET_EN
        $display("[TB] CALL and RET");
        clearRom();
        rom[0]  = 8'hC0;
        rom[1]  = 8'h10;
        rom[16] = 8'hD0;
        doReset();
        checkOutput("call_pc0", pc, 8'h00);
        run = 1'b1;
        tick(1);
        checkOutput("call_pc1", pc, 8'h01);
        tick(1);
        checkOutput("call_pc16", pc, 8'h10);
        checkOutput("call_ret_pc", u_dut.ret_pc_q, 8'h02);
        tick(1);
        checkOutput("call_pc17", pc, 8'h11);
        tick(1);
        checkOutput("ret_pc2", pc, 8'h02);
        run = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
